// File: rtl/lfgm_seq_ctrl_if.sv
// Handshake/bus bundle between frame/UI control, the generation sequencer,
// and the cell RAM / line generator.
interface lfgm_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned GCNT_W = 16
);
    logic              start;
    logic              run;
    logic              step;
    logic              rgen_req;
    logic [4:0]        state;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_wall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              bank;
    logic              wcf;
    logic              rgen_en;
    logic              busy;
    logic              gen_done;
    logic [GCNT_W-1:0] gen_cnt;

    // UI / datapath side
    modport master (
        output start, run, step, rgen_req,
        input  state, rd_en, rd_addr, rd_wall, wr_en, wr_addr,
               bank, wcf, rgen_en, busy, gen_done, gen_cnt
    );

    // sequencer side
    modport slave (
        input  start, run, step, rgen_req,
        output state, rd_en, rd_addr, rd_wall, wr_en, wr_addr,
               bank, wcf, rgen_en, busy, gen_done, gen_cnt
    );
endinterface

// File: rtl/lfgm_seq_ctrl.sv
// Lifegame generation sequencer: walks every cell line through a fixed
// 16-cycle read/judge/write slot and swaps the RAM bank per generation.
module lfgm_seq_ctrl #(
    parameter int unsigned LINES  = 60,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned GCNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfgm_seq_ctrl_if.slave bus
);

    typedef enum logic [4:0] {
        S_PRE_READ_1 = 5'd0,
        S_READ       = 5'd1,
        S_LAT_A      = 5'd2,
        S_LAT_B      = 5'd3,
        S_LAT_C      = 5'd4,
        S_SHIFTIN    = 5'd5,
        S_CHK_UL     = 5'd6,
        S_CHK_UP     = 5'd7,
        S_CHK_UR     = 5'd8,
        S_CHK_L      = 5'd9,
        S_CHK_R      = 5'd10,
        S_CHK_LL     = 5'd11,
        S_CHK_LO     = 5'd12,
        S_CHK_LR     = 5'd13,
        S_JDG        = 5'd14,
        S_DLT        = 5'd15,
        S_WRITE      = 5'd16,
        S_WAIT       = 5'd17
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] line_q, line_d;
    logic              bank_q, bank_d;
    logic [GCNT_W-1:0] gen_cnt_q, gen_cnt_d;
    logic              step_pend_q, step_pend_d;
    logic              rgen_pend_q, rgen_pend_d;
    logic              rgen_en_q, rgen_en_d;
    logic              gen_done_q, gen_done_d;
    logic              go;
    logic              last_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            line_q      <= '0;
            bank_q      <= 1'b0;
            gen_cnt_q   <= '0;
            step_pend_q <= 1'b0;
            rgen_pend_q <= 1'b0;
            rgen_en_q   <= 1'b0;
            gen_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            bank_q      <= bank_d;
            gen_cnt_q   <= gen_cnt_d;
            step_pend_q <= step_pend_d;
            rgen_pend_q <= rgen_pend_d;
            rgen_en_q   <= rgen_en_d;
            gen_done_q  <= gen_done_d;
        end
    end

    assign last_line = (line_q == LAST_LINE);
    assign go        = (state_q == S_WAIT) && bus.start && (bus.run || step_pend_q);

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        bank_d      = bank_q;
        gen_cnt_d   = gen_cnt_q;
        rgen_en_d   = rgen_en_q;
        gen_done_d  = 1'b0;
        // Pending requests survive until consumed by the WAIT->PRE_READ_1 launch.
        step_pend_d = (step_pend_q && !go) || bus.step;
        rgen_pend_d = (rgen_pend_q && !go) || bus.rgen_req;

        unique case (state_q)
            S_WAIT: begin
                if (go) begin
                    state_d   = S_PRE_READ_1;
                    rgen_en_d = rgen_pend_q;
                end
            end
            S_PRE_READ_1: begin
                line_d  = '0;
                state_d = S_READ;
            end
            S_WRITE: begin
                if (last_line) begin
                    state_d    = S_WAIT;
                    bank_d     = ~bank_q;
                    gen_cnt_d  = gen_cnt_q + GCNT_W'(1);
                    gen_done_d = 1'b1;
                    rgen_en_d  = 1'b0;
                end else begin
                    line_d  = line_q + ADDR_W'(1);
                    state_d = S_READ;
                end
            end
            default: state_d = state_e'(state_q + 5'd1);
        endcase
    end

    // Outputs decode registered state only, so inputs never reach outputs combinationally.
    assign bus.state    = state_q;
    assign bus.rd_en    = (state_q == S_PRE_READ_1) || ((state_q == S_READ) && !last_line);
    assign bus.rd_addr  = ((state_q == S_READ) && !last_line) ? line_q + ADDR_W'(1) : '0;
    assign bus.rd_wall  = (state_q == S_READ) && last_line;
    assign bus.wr_en    = (state_q == S_WRITE);
    assign bus.wr_addr  = (state_q == S_WRITE) ? line_q : '0;
    assign bus.bank     = bank_q;
    assign bus.wcf      = (state_q >= S_SHIFTIN) && (state_q <= S_JDG);
    assign bus.rgen_en  = rgen_en_q;
    assign bus.busy     = (state_q != S_WAIT);
    assign bus.gen_done = gen_done_q;
    assign bus.gen_cnt  = gen_cnt_q;

endmodule

// File: tb/tb_lfgm_seq_ctrl.sv
// Self-checking bench for lfgm_seq_ctrl: table-driven step/idle vectors plus
// full-generation sequences checked cycle by cycle against a reference model.
module tb_lfgm_seq_ctrl;

    localparam int unsigned LINES  = 60;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned GCNT_W = 16;
    localparam int          GEN_LEN = 1 + 16 * LINES;

    logic clk;
    logic rst;

    lfgm_seq_ctrl_if #(.ADDR_W(ADDR_W), .GCNT_W(GCNT_W)) bus ();

    lfgm_seq_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W), .GCNT_W(GCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        run;
        logic        step;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[22];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_bank = 1'b0;
    int   exp_cnt  = 0;

    function automatic logic [24:0] mk_out(input int st, input bit rde, input int ra,
                                           input bit rw, input bit wre, input int wa,
                                           input bit bk, input bit wc, input bit re,
                                           input bit bz, input bit gd);
        return {5'(st), rde, 6'(ra), rw, wre, 6'(wa), bk, wc, re, bz, gd};
    endfunction

    function automatic logic [24:0] act_out();
        return {bus.state, bus.rd_en, bus.rd_addr, bus.rd_wall, bus.wr_en, bus.wr_addr,
                bus.bank, bus.wcf, bus.rgen_en, bus.busy, bus.gen_done};
    endfunction

    // Reference model: k=0 is PRE_READ_1, k=GEN_LEN is the first WAIT cycle.
    function automatic logic [24:0] exp_gen(input int k, input bit rg, input bit bk);
        int line;
        int ph;
        int st;
        if (k == 0)
            return mk_out(0, 1, 0, 0, 0, 0, bk, 0, rg, 1, 0);
        if (k >= GEN_LEN)
            return mk_out(17, 0, 0, 0, 0, 0, ~bk, 0, 0, 0, 1);
        line = (k - 1) / 16;
        ph   = (k - 1) % 16;
        st   = ph + 1;
        return mk_out(st,
                      (ph == 0) && (line < LINES - 1),
                      ((ph == 0) && (line < LINES - 1)) ? line + 1 : 0,
                      (ph == 0) && (line == LINES - 1),
                      ph == 15,
                      (ph == 15) ? line : 0,
                      bk,
                      (st >= 5) && (st <= 14),
                      rg, 1, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Launch one generation from WAIT with run=1 and follow it for stop_at+1 cycles.
    task automatic run_gen(input bit rg, input int pulse_at, input int stop_at);
        bus.start = 1'b1;
        for (int k = 0; k <= stop_at; k++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.rgen_req = (k == pulse_at);
            chk($sformatf("gen_k%0d", k), 32'(act_out()), 32'(exp_gen(k, rg, exp_bank)));
        end
        bus.rgen_req = 1'b0;
        if (stop_at >= GEN_LEN) begin
            exp_bank = ~exp_bank;
            exp_cnt++;
            chk("gen_cnt", 32'(bus.gen_cnt), 32'(exp_cnt));
            @(negedge clk);
            chk("post_wait", 32'(act_out()),
                32'(mk_out(17, 0, 0, 0, 0, 0, exp_bank, 0, 0, 0, 0)));
        end
    endtask

    initial begin
        int k;

        // Idle/step table: inputs applied, outputs checked one clock later.
        for (int i = 0; i < 4; i++)
            tbl[i] = '{start: (i % 2 == 0), run: 1'b0, step: (i == 3),
                       exp: mk_out(17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4] = '{1'b1, 1'b0, 1'b0, mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[5] = '{1'b0, 1'b0, 1'b0, mk_out(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[6] = '{1'b1, 1'b0, 1'b0, mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7] = '{1'b0, 1'b0, 1'b0, mk_out(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[8] = '{1'b0, 1'b0, 1'b0, mk_out(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        for (int i = 9; i <= 18; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, mk_out(i - 4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0)};
        tbl[19] = '{1'b0, 1'b0, 1'b0, mk_out(15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[20] = '{1'b0, 1'b0, 1'b0, mk_out(16, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)};
        tbl[21] = '{1'b0, 1'b0, 1'b0, mk_out(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0)};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.rgen_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(act_out()), 32'(mk_out(17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset_cnt", 32'(bus.gen_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus.start = tbl[i].start;
            bus.run   = tbl[i].run;
            bus.step  = tbl[i].step;
            @(negedge clk);
            chk($sformatf("tbl_%0d", i), 32'(act_out()), 32'(tbl[i].exp));
        end
        bus.start = 1'b0;

        // Finish the stepped generation; bounded wait for WAIT.
        k = 17;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (bus.state == 5'd17) break;
        end
        chk("step_gen_len", 32'(k), 32'(GEN_LEN));
        chk("step_gen_done", 32'(act_out()), 32'(mk_out(17, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1)));
        chk("step_gen_cnt", 32'(bus.gen_cnt), 32'd1);
        exp_bank = 1'b1;
        exp_cnt  = 1;
        @(negedge clk);
        chk("gen_done_pulse", 32'(bus.gen_done), 32'd0);

        // Step consumed: further starts with run=0 must be ignored.
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("step_once", 32'(act_out()), 32'(mk_out(17, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
        end
        bus.start = 1'b0;
        @(negedge clk);

        bus.run = 1'b1;
        run_gen(1'b0, 300, GEN_LEN);
        run_gen(1'b1, -1, GEN_LEN);
        run_gen(1'b0, -1, GEN_LEN);

        // Reset while in CHK_UP of line 30.
        run_gen(1'b0, -1, 1 + 30 * 16 + 6);
        chk("at_chk_up", 32'(bus.state), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("midgen_rst_out", 32'(act_out()), 32'(mk_out(17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        chk("midgen_rst_cnt", 32'(bus.gen_cnt), 32'd0);
        rst      = 1'b0;
        exp_bank = 1'b0;
        exp_cnt  = 0;
        @(negedge clk);
        run_gen(1'b0, -1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
